// File: rtl/key_input_pkg.sv
// Shared constants, FSM state type and width helper for the key input conditioner.
package key_input_pkg;

  localparam int unsigned NUM_KEYS  = 4;
  localparam int unsigned KEY_IDX_W = $clog2(NUM_KEYS);

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_LONG_CYCLES     = 50000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 12500000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_e;

  // Bits needed to hold the values 0..max_val without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, hold timer and
// press/release/long pulses. Auto-repeat is built only when
// KEY_INPUT_CONDITIONER_AUTOREPEAT_EN is defined.
module key_debounce_cell
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
`ifdef KEY_INPUT_CONDITIONER_AUTOREPEAT_EN
  ,parameter int unsigned REPEAT_CYCLES  = DEF_REPEAT_CYCLES
`endif
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic          sync1, sync2;
  logic          synced;
  key_state_e    state, state_nxt;
  logic [DW-1:0] db_cnt, db_cnt_nxt, db_inc;
  logic          db_done;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          press_acc, press_nxt, press_q;
  logic          release_nxt, release_q;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign synced  = ~sync2;
  assign db_inc  = db_cnt + DW'(1);
  assign db_done = (db_inc == DB_DONE);

  // Debounce FSM: the cycle that first sees a new level counts as the first stable cycle.
  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    press_acc   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE, PRESS_DB: begin
        if (!synced) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_done) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
          press_acc  = 1'b1;
        end else begin
          state_nxt  = PRESS_DB;
          db_cnt_nxt = db_inc;
        end
      end
      HELD, REL_DB: begin
        if (synced) begin
          state_nxt  = HELD;
          db_cnt_nxt = '0;
        end else if (db_done) begin
          state_nxt   = IDLE;
          db_cnt_nxt  = '0;
          release_nxt = 1'b1;
        end else begin
          state_nxt  = REL_DB;
          db_cnt_nxt = db_inc;
        end
      end
      default: begin
        state_nxt  = IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

  assign key_level = (state == HELD) || (state == REL_DB);
  assign key_long  = key_level && (hold_cnt == HOLD_FIRE);

  // Hold timer restarts only on an accepted press, so a release bounce that
  // falls back into HELD cannot produce a second key_long for the same press.
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (press_acc || state_nxt == IDLE) begin
      hold_cnt_nxt = '0;
    end else if (key_level && hold_cnt != HOLD_SAT) begin
      hold_cnt_nxt = hold_cnt + HW'(1);
    end
  end

`ifdef KEY_INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt, rep_cnt_nxt, rep_base;
  logic          armed, armed_nxt, repeat_fire;

  // Auto-repeat timer; the key_long cycle itself is phase 0 of the repeat period.
  always_comb begin
    rep_base    = key_long ? '0 : rep_cnt;
    rep_cnt_nxt = '0;
    armed_nxt   = 1'b0;
    repeat_fire = 1'b0;
    if ((armed || key_long) && state == HELD && state_nxt == HELD) begin
      armed_nxt = 1'b1;
      if (rep_base == REP_LAST) begin
        repeat_fire = 1'b1;
      end else begin
        rep_cnt_nxt = rep_base + RW'(1);
      end
    end
  end

  assign press_nxt = press_acc | repeat_fire;
`else
  assign press_nxt = press_acc;
`endif

  // State, counters and registered pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_INPUT_CONDITIONER_AUTOREPEAT_EN
      rep_cnt   <= '0;
      armed     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      db_cnt    <= db_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
`ifdef KEY_INPUT_CONDITIONER_AUTOREPEAT_EN
      rep_cnt   <= rep_cnt_nxt;
      armed     <= armed_nxt;
`endif
    end
  end

  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Conditions the four active-low board keys into debounced levels, event
// pulses and a sticky last-selected-key code. Optional auto-repeat is enabled
// with the macro KEY_INPUT_CONDITIONER_AUTOREPEAT_EN.
module key_input_conditioner
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [NUM_KEYS-1:0]  KEY,
  output logic [NUM_KEYS-1:0]  key_level,
  output logic [NUM_KEYS-1:0]  key_press,
  output logic [NUM_KEYS-1:0]  key_release,
  output logic [NUM_KEYS-1:0]  key_long,
  output logic                 sel_valid,
  output logic [KEY_IDX_W-1:0] sel_code
);

  if (DEBOUNCE_CYCLES == 0 || LONG_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_param_check
    $error("key_input_conditioner: cycle parameters must be at least 1");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
`ifdef KEY_INPUT_CONDITIONER_AUTOREPEAT_EN
      ,.REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_cell (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .key_n      (KEY[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

  logic                 sel_hit;
  logic                 sel_found;
  logic [KEY_IDX_W-1:0] sel_idx;

  // Priority encode: lowest pressed index wins.
  always_comb begin
    sel_hit   = |key_press;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (key_press[i] && !sel_found) begin
        sel_idx   = KEY_IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Sticky selection register, updated only by press pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sel_valid <= 1'b0;
      sel_code  <= '0;
    end else if (sel_hit) begin
      sel_valid <= 1'b1;
      sel_code  <= sel_idx;
    end
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with a cycle-level behavioural model.
module tb_key_input_conditioner;

  localparam int D = 8;
  localparam int L = 32;
  localparam int R = 16;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [3:0] key_level, key_press, key_release, key_long;
  logic       sel_valid;
  logic [1:0] sel_code;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  key_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .sel_valid  (sel_valid),
    .sel_code   (sel_code)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Model: raw key reaches the logic two samples late; a level flips after D
  // consecutive cycles of disagreement; long fires L-1 cycles after the press.
  logic [3:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_long;
  logic       m_sel_valid;
  logic [1:0] m_sel_code;
  int         m_run[4], m_hold[4], m_next[4];
  bit         m_armed[4];

  always @(posedge CLOCK_50) begin : model
    logic [3:0] prev_press;
    logic       syn;
    logic       stable;
    cyc = cyc + 1;
    if (reset) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
      m_sel_valid = 1'b0; m_sel_code = '0;
      for (int k = 0; k < 4; k++) begin
        m_run[k] = 0; m_hold[k] = 0; m_next[k] = 0; m_armed[k] = 1'b0;
      end
    end else begin
      prev_press = m_press;
      for (int k = 0; k < 4; k++) begin
        syn = ~m_s2[k];
        m_press[k] = 1'b0;
        m_rel[k]   = 1'b0;
        if (m_lvl[k]) m_hold[k] = (m_hold[k] < L) ? m_hold[k] + 1 : L;
        if (syn != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_lvl[k] = syn;
            m_run[k] = 0;
            if (syn) begin
              m_press[k] = 1'b1;
              m_hold[k]  = 0;
            end else begin
              m_rel[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
        m_long[k] = m_lvl[k] && (m_hold[k] == L - 1);
        stable = m_lvl[k] && (m_run[k] == 0);
`ifdef KEY_INPUT_CONDITIONER_AUTOREPEAT_EN
        if (m_armed[k] && !stable) m_armed[k] = 1'b0;
        if (m_armed[k] && cyc == m_next[k]) begin
          m_press[k] = 1'b1;
          m_next[k]  = m_next[k] + R;
        end
        if (m_long[k] && stable) begin
          m_armed[k] = 1'b1;
          m_next[k]  = cyc + R;
        end
`else
        if (stable) m_armed[k] = 1'b0;
`endif
      end
      m_s2 = m_s1;
      m_s1 = KEY;
      if (|prev_press) begin
        m_sel_valid = 1'b1;
        for (int k = 3; k >= 0; k--) if (prev_press[k]) m_sel_code = 2'(k);
      end
    end
  end

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge CLOCK_50) begin
    if (cyc >= 1) begin
      cmp("key_level",   8'(key_level),   8'(m_lvl));
      cmp("key_press",   8'(key_press),   8'(m_press));
      cmp("key_release", 8'(key_release), 8'(m_rel));
      cmp("key_long",    8'(key_long),    8'(m_long));
      cmp("sel_valid",   8'(sel_valid),   8'(m_sel_valid));
      cmp("sel_code",    8'(sel_code),    8'(m_sel_code));
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    wait_cyc(c);
    @(negedge CLOCK_50);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d actual running required finished", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t0;
    reset = 1'b1;
    KEY   = 4'hF;

    at_neg(2);
    cmp("lit_rst_level", 8'(key_level), 8'h00);
    cmp("lit_rst_valid", 8'(sel_valid), 8'h00);
    cmp("lit_rst_long",  8'(key_long),  8'h00);
    wait_cyc(3);
    reset = 1'b0;

    // Bounce on KEY[0]: 3-cycle runs never reach D.
    t0 = 5;
    for (int i = 0; i < 10; i++) begin
      wait_cyc(t0 + 3 * i);
      KEY = (i % 2 == 0) ? 4'b1110 : 4'b1111;
    end
    wait_cyc(t0 + 30);
    KEY = 4'hF;
    at_neg(t0 + 45);
    cmp("lit_bounce_level", 8'(key_level), 8'h00);
    cmp("lit_bounce_valid", 8'(sel_valid), 8'h00);

    // KEY[3] low for D-1 cycles: rejected.
    t0 = 55;
    wait_cyc(t0);     KEY = 4'b0111;
    wait_cyc(t0 + 7); KEY = 4'hF;
    at_neg(t0 + 20);
    cmp("lit_glitch7_valid", 8'(sel_valid), 8'h00);

    // KEY[3] low for exactly D cycles: accepted.
    t0 = 80;
    wait_cyc(t0);     KEY = 4'b0111;
    wait_cyc(t0 + 8); KEY = 4'hF;
    at_neg(t0 + 9);
    cmp("lit_glitch8_level_pre", 8'(key_level), 8'h00);
    at_neg(t0 + 10);
    cmp("lit_glitch8_press", 8'(key_press), 8'h08);
    at_neg(t0 + 11);
    cmp("lit_glitch8_code",  8'(sel_code),  8'h03);
    cmp("lit_glitch8_valid", 8'(sel_valid), 8'h01);
    at_neg(t0 + 18);
    cmp("lit_glitch8_release", 8'(key_release), 8'h08);

    // Clean press of KEY[2] for 20 cycles.
    t0 = 105;
    wait_cyc(t0); KEY = 4'b1011;
    at_neg(t0 + 9);
    cmp("lit_clean_level_pre", 8'(key_level), 8'h00);
    at_neg(t0 + 10);
    cmp("lit_clean_press", 8'(key_press), 8'h04);
    cmp("lit_clean_level", 8'(key_level), 8'h04);
    at_neg(t0 + 11);
    cmp("lit_clean_code",      8'(sel_code),  8'h02);
    cmp("lit_clean_press_end", 8'(key_press), 8'h00);
    wait_cyc(t0 + 20); KEY = 4'hF;
    at_neg(t0 + 29);
    cmp("lit_clean_level_hold", 8'(key_level), 8'h04);
    at_neg(t0 + 30);
    cmp("lit_clean_release", 8'(key_release), 8'h04);
    cmp("lit_clean_code_kept", 8'(sel_code), 8'h02);

    // KEY[3] and KEY[1] together: lowest index selected.
    t0 = 145;
    wait_cyc(t0); KEY = 4'b0101;
    at_neg(t0 + 10);
    cmp("lit_simul_press", 8'(key_press), 8'h0A);
    at_neg(t0 + 11);
    cmp("lit_simul_code", 8'(sel_code), 8'h01);
    wait_cyc(t0 + 12); KEY = 4'hF;
    at_neg(t0 + 22);
    cmp("lit_simul_release", 8'(key_release), 8'h0A);

    // Long press of KEY[1] for 60 cycles.
    t0 = 180;
    wait_cyc(t0); KEY = 4'b1101;
    at_neg(t0 + 10);
    cmp("lit_long_press", 8'(key_press), 8'h02);
    at_neg(t0 + 40);
    cmp("lit_long_early", 8'(key_long), 8'h00);
    at_neg(t0 + 41);
    cmp("lit_long_fire", 8'(key_long), 8'h02);
    at_neg(t0 + 42);
    cmp("lit_long_once", 8'(key_long), 8'h00);
    at_neg(t0 + 57);
`ifdef KEY_INPUT_CONDITIONER_AUTOREPEAT_EN
    cmp("lit_long_repeat", 8'(key_press), 8'h02);
`else
    cmp("lit_long_norepeat", 8'(key_press), 8'h00);
`endif
    wait_cyc(t0 + 60); KEY = 4'hF;
    at_neg(t0 + 70);
    cmp("lit_long_release", 8'(key_release), 8'h02);

    // Reset while KEY[0] is held: no release, re-debounce afterwards.
    t0 = 265;
    wait_cyc(t0); KEY = 4'b1110;
    at_neg(t0 + 10);
    cmp("lit_rmid_press", 8'(key_press), 8'h01);
    wait_cyc(t0 + 20); reset = 1'b1;
    wait_cyc(t0 + 21); reset = 1'b0;
    at_neg(t0 + 21);
    cmp("lit_rmid_level",   8'(key_level),   8'h00);
    cmp("lit_rmid_valid",   8'(sel_valid),   8'h00);
    cmp("lit_rmid_release", 8'(key_release), 8'h00);
    at_neg(t0 + 30);
    cmp("lit_rmid_level_pre", 8'(key_level), 8'h00);
    at_neg(t0 + 31);
    cmp("lit_rmid_repress", 8'(key_press), 8'h01);
    wait_cyc(t0 + 35); KEY = 4'hF;
    at_neg(t0 + 50);
    cmp("lit_rmid_final_level", 8'(key_level), 8'h00);

    repeat (3) @(posedge CLOCK_50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
